// File: rtl/keccak_permute_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_permute_ctrl
//
// Control FSM for the Keccak-f permutation stage of the SHAKE pipeline. It sits
// between the input block buffer and the output digest buffer and sequences the
// absorb, permute, dump and squeeze phases. It owns the round-group counter,
// supports unrolled rounds, counts the requested output blocks and flags the
// final output block.
//
// Optional feature macro: PERMUTE_PERF_CNT_EN
//   defined   : perf_blocks counts in_ack pulses, perf_stalls counts DUMP cycles
//               with out_ready low; both are 32-bit, saturate and clear on rst.
//   undefined : both perf ports are tied to 0 and no counter flops exist.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      input buffer holds a block
//   in_last       held block is the message's last (qualified by in_valid)
//   in_outblocks  output blocks requested, sampled with a message's first block
//   in_ack        one-cycle pulse, block consumed
//   out_ready     output buffer free
//   out_we        write the current state into the output buffer
//   out_last      qualifies out_we: final output block
//   state_reset   zero the Keccak state
//   ctrl_load     capture per-message control into the datapath
//   absorb_en     XOR the input block into the state
//   round_en      apply ROUND_UNROLL rounds this cycle
//   round_idx     round-group index (0 whenever round_en is low)
//   busy          message in progress
//   perf_blocks   absorbed-block count
//   perf_stalls   output-stall cycle count
//
// Handshake: a block is taken from the input buffer exactly in the cycle where
// in_ack is high (in_valid was high in IDLE or WAIT_IN); an output block is
// written exactly in the cycle where out_we is high (out_ready was high in
// DUMP). All control outputs are combinational (Mealy) and forced to 0 while
// rst is high.
// -----------------------------------------------------------------------------
module keccak_permute_ctrl #(
  parameter int NUM_ROUNDS   = 24,
  parameter int ROUND_UNROLL = 1,
  parameter int OUT_CNT_W    = 16,
  localparam int RC  = NUM_ROUNDS / ROUND_UNROLL,
  localparam int RIW = (RC > 1) ? $clog2(RC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [OUT_CNT_W-1:0] in_outblocks,
  output logic                 in_ack,
  input  logic                 out_ready,
  output logic                 out_we,
  output logic                 out_last,
  output logic                 state_reset,
  output logic                 ctrl_load,
  output logic                 absorb_en,
  output logic                 round_en,
  output logic [RIW-1:0]       round_idx,
  output logic                 busy,
  output logic [31:0]          perf_blocks,
  output logic [31:0]          perf_stalls
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ABSORB  = 3'd2,
    S_PERMUTE = 3'd3,
    S_WAIT_IN = 3'd4,
    S_DUMP    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 sq_q, sq_d;
  logic [OUT_CNT_W-1:0] rem_q, rem_d;
  logic [RIW-1:0]       rnd_q, rnd_d;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sq_d        = sq_q;
    rem_d       = rem_q;
    rnd_d       = rnd_q;
    in_ack      = 1'b0;
    out_we      = 1'b0;
    out_last    = 1'b0;
    state_reset = 1'b0;
    ctrl_load   = 1'b0;
    absorb_en   = 1'b0;
    round_en    = 1'b0;
    round_idx   = '0;
    busy        = 1'b0;
    // While rst is high every output stays 0; the register block forces INIT.
    if (!rst) begin
      case (state_q)
        S_INIT: begin
          state_reset = 1'b1;
          state_d     = S_IDLE;
        end
        S_IDLE: begin
          if (in_valid) begin
            absorb_en = 1'b1;
            in_ack    = 1'b1;
            ctrl_load = 1'b1;
            last_d    = in_last;
            // A request of zero output blocks still yields one block.
            rem_d     = (in_outblocks == '0) ? OUT_CNT_W'(1) : in_outblocks;
            sq_d      = 1'b0;
            state_d   = S_PERMUTE;
          end
        end
        S_PERMUTE: begin
          busy      = 1'b1;
          round_en  = 1'b1;
          round_idx = rnd_q;
          if (rnd_q == RIW'(RC - 1)) begin
            rnd_d = '0;
            if (sq_q || last_q) begin
              sq_d    = 1'b1;
              state_d = S_DUMP;
            end else begin
              state_d = S_WAIT_IN;
            end
          end else begin
            rnd_d = rnd_q + RIW'(1);
          end
        end
        S_WAIT_IN: begin
          busy = 1'b1;
          if (in_valid) begin
            absorb_en = 1'b1;
            in_ack    = 1'b1;
            last_d    = in_last;
            state_d   = S_PERMUTE;
          end
        end
        S_DUMP: begin
          busy = 1'b1;
          // in_valid is deliberately ignored here; a new message waits for IDLE.
          if (out_ready) begin
            out_we   = 1'b1;
            out_last = (rem_q == OUT_CNT_W'(1));
            rem_d    = rem_q - OUT_CNT_W'(1);
            if (rem_q == OUT_CNT_W'(1)) begin
              state_reset = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d = S_PERMUTE;
            end
          end
        end
        S_ABSORB: begin
          // Absorption is folded into the accepting IDLE/WAIT_IN cycle, so this
          // encoding is never entered; recover through INIT if it ever is.
          busy    = 1'b1;
          state_d = S_INIT;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      last_q  <= 1'b0;
      sq_q    <= 1'b0;
      rem_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sq_q    <= sq_d;
      rem_q   <= rem_d;
      rnd_q   <= rnd_d;
    end
  end

`ifdef PERMUTE_PERF_CNT_EN
  logic [31:0] perf_blocks_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (in_ack && (perf_blocks_q != '1)) begin
        perf_blocks_q <= perf_blocks_q + 32'd1;
      end
      if ((state_q == S_DUMP) && !out_ready && (perf_stalls_q != '1)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_blocks = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_keccak_permute_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keccak_permute_ctrl
//
// Bench for keccak_permute_ctrl. dut drives NUM_ROUNDS=24, ROUND_UNROLL=1;
// dut2 drives the same FSM with ROUND_UNROLL=2. Expected round indices and
// out_last values are queued when a message is started and popped as the DUT
// raises round_en / out_we. Cycle numbers are counted from the accepting cycle
// (cycle 0). Inputs change just after the falling edge; outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_keccak_permute_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // dut (24 rounds, unroll 1)
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_outblocks;
  logic        in_ack, out_we, out_last, state_reset, ctrl_load, absorb_en;
  logic        round_en, busy;
  logic [4:0]  round_idx;
  logic [31:0] perf_blocks, perf_stalls;

  // dut2 (24 rounds, unroll 2)
  logic        in_valid2, in_last2, out_ready2;
  logic [15:0] in_outblocks2;
  logic        in_ack2, out_we2, out_last2, state_reset2, ctrl_load2, absorb_en2;
  logic        round_en2, busy2;
  logic [3:0]  round_idx2;
  logic [31:0] perf_blocks2, perf_stalls2;

  keccak_permute_ctrl #(.NUM_ROUNDS(24), .ROUND_UNROLL(1), .OUT_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_outblocks(in_outblocks), .in_ack(in_ack), .out_ready(out_ready),
    .out_we(out_we), .out_last(out_last), .state_reset(state_reset),
    .ctrl_load(ctrl_load), .absorb_en(absorb_en), .round_en(round_en),
    .round_idx(round_idx), .busy(busy), .perf_blocks(perf_blocks),
    .perf_stalls(perf_stalls)
  );

  keccak_permute_ctrl #(.NUM_ROUNDS(24), .ROUND_UNROLL(2), .OUT_CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_last(in_last2),
    .in_outblocks(in_outblocks2), .in_ack(in_ack2), .out_ready(out_ready2),
    .out_we(out_we2), .out_last(out_last2), .state_reset(state_reset2),
    .ctrl_load(ctrl_load2), .absorb_en(absorb_en2), .round_en(round_en2),
    .round_idx(round_idx2), .busy(busy2), .perf_blocks(perf_blocks2),
    .perf_stalls(perf_stalls2)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_idx_q[$];
  logic [3:0] exp_idx2_q[$];
  logic [0:0] exp_last_q[$];

  // ---------------------------------------------------------------- driver
  task automatic start_msg(input logic last, input logic [15:0] nout, input int nperm);
    @(negedge clk);
    in_valid = 1'b1; in_last = last; in_outblocks = nout; out_ready = 1'b1;
    for (int p = 0; p < nperm; p++)
      for (int i = 0; i < 24; i++) exp_idx_q.push_back(5'(i));
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_outblocks = 16'd1; out_ready = 1'b1;
    in_valid2 = 1'b1; in_last2 = 1'b1; in_outblocks2 = 16'd1; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({in_ack, out_we, out_last, state_reset, ctrl_load, absorb_en, round_en,
         round_idx, busy, perf_blocks, perf_stalls} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b we=%b sr=%b re=%b idx=%0d busy=%b pb=%0d ps=%0d want all 0",
               in_ack, out_we, state_reset, round_en, round_idx, busy, perf_blocks, perf_stalls);
    end
    n_cmp++;
    if ({in_ack2, out_we2, out_last2, state_reset2, ctrl_load2, absorb_en2, round_en2,
         round_idx2, busy2, perf_blocks2, perf_stalls2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs2: got ack=%b we=%b sr=%b re=%b busy=%b want all 0",
               in_ack2, out_we2, state_reset2, round_en2, busy2);
    end
    // First cycle after reset is INIT: state_reset, and in_valid is not taken.
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({state_reset, busy, in_ack, absorb_en} !== 4'b1000) begin
      n_err++;
      $display("FAIL init_cycle: got sr/busy/ack/abs=%b want 1000", {state_reset, busy, in_ack, absorb_en});
    end
    n_cmp++;
    if ({state_reset2, busy2, in_ack2} !== 3'b100) begin
      n_err++;
      $display("FAIL init_cycle2: got sr/busy/ack=%b want 100", {state_reset2, busy2, in_ack2});
    end
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0;
    #1;
    n_cmp++;
    if ({state_reset, busy, round_en, out_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_cycle: got sr/busy/re/we=%b want 0000", {state_reset, busy, round_en, out_we});
    end
  endtask

  task automatic test_single(input string tag);
    int writes = 0;
    logic [4:0] e_idx;
    logic [0:0] e_last;
    start_msg(1'b1, 16'd1, 1);
    exp_last_q.push_back(1'b1);
    n_cmp++;
    if ({absorb_en, in_ack, ctrl_load, busy} !== 4'b1110) begin
      n_err++;
      $display("FAIL %s_accept: got abs/ack/ld/busy=%b want 1110", tag, {absorb_en, in_ack, ctrl_load, busy});
    end
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (round_en !== (c >= 1 && c <= 24)) begin
        n_err++;
        $display("FAIL %s_round_en c=%0d: got %b want %b", tag, c, round_en, (c >= 1 && c <= 24));
      end
      if (round_en === 1'b1 && exp_idx_q.size() > 0) begin
        e_idx = exp_idx_q.pop_front();
        n_cmp++;
        if (round_idx !== e_idx) begin
          n_err++;
          $display("FAIL %s_round_idx c=%0d: got %0d want %0d", tag, c, round_idx, e_idx);
        end
      end
      n_cmp++;
      if (out_we !== (c == 25)) begin
        n_err++;
        $display("FAIL %s_out_we c=%0d: got %b want %b", tag, c, out_we, (c == 25));
      end
      if (out_we === 1'b1 && exp_last_q.size() > 0) begin
        e_last = exp_last_q.pop_front();
        n_cmp++;
        if ({out_last, state_reset} !== {e_last, 1'b1}) begin
          n_err++;
          $display("FAIL %s_out_last c=%0d: got last/sr=%b want %b1", tag, c, {out_last, state_reset}, e_last);
        end
        writes++;
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy_end: got %b want 0", tag, busy);
    end
    n_cmp++;
    if (exp_idx_q.size() != 0 || exp_last_q.size() != 0 || writes != 1) begin
      n_err++;
      $display("FAIL %s_leftover: got idx_left=%0d last_left=%0d writes=%0d want 0 0 1",
               tag, exp_idx_q.size(), exp_last_q.size(), writes);
    end
    exp_idx_q.delete(); exp_last_q.delete();
  endtask

  task automatic test_unroll2();
    logic [3:0] e_idx;
    int writes = 0;
    @(negedge clk);
    in_valid2 = 1'b1; in_last2 = 1'b1; in_outblocks2 = 16'd1; out_ready2 = 1'b1;
    for (int i = 0; i < 12; i++) exp_idx2_q.push_back(4'(i));
    #1;
    n_cmp++;
    if ({absorb_en2, in_ack2, ctrl_load2} !== 3'b111) begin
      n_err++;
      $display("FAIL u2_accept: got abs/ack/ld=%b want 111", {absorb_en2, in_ack2, ctrl_load2});
    end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      n_cmp++;
      if (round_en2 !== (c <= 12)) begin
        n_err++;
        $display("FAIL u2_round_en c=%0d: got %b want %b", c, round_en2, (c <= 12));
      end
      if (round_en2 === 1'b1 && exp_idx2_q.size() > 0) begin
        e_idx = exp_idx2_q.pop_front();
        n_cmp++;
        if (round_idx2 !== e_idx) begin
          n_err++;
          $display("FAIL u2_round_idx c=%0d: got %0d want %0d", c, round_idx2, e_idx);
        end
      end
      n_cmp++;
      if (out_we2 !== (c == 13)) begin
        n_err++;
        $display("FAIL u2_out_we c=%0d: got %b want %b", c, out_we2, (c == 13));
      end
      if (out_we2 === 1'b1) begin
        writes++;
        n_cmp++;
        if ({out_last2, state_reset2} !== 2'b11) begin
          n_err++;
          $display("FAIL u2_out_last: got last/sr=%b want 11", {out_last2, state_reset2});
        end
      end
    end
    n_cmp++;
    if (busy2 !== 1'b0 || exp_idx2_q.size() != 0 || writes != 1) begin
      n_err++;
      $display("FAIL u2_end: got busy=%b idx_left=%0d writes=%0d want 0 0 1", busy2, exp_idx2_q.size(), writes);
    end
    exp_idx2_q.delete();
  endtask

  task automatic test_two_blocks();
    logic [4:0] e_idx;
    logic       exp_re;
    start_msg(1'b0, 16'd1, 2);
    exp_last_q.push_back(1'b1);
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      in_valid = (c == 30); in_last = (c == 30);
      #1;
      exp_re = (c >= 1 && c <= 24) || (c >= 31 && c <= 54);
      n_cmp++;
      if ({in_ack, absorb_en} !== {2{c == 30}} || ctrl_load !== 1'b0) begin
        n_err++;
        $display("FAIL two_ack c=%0d: got ack/abs/ld=%b%b%b want %b%b0", c, in_ack, absorb_en, ctrl_load, c == 30, c == 30);
      end
      n_cmp++;
      if (round_en !== exp_re) begin
        n_err++;
        $display("FAIL two_round_en c=%0d: got %b want %b", c, round_en, exp_re);
      end
      if (round_en === 1'b1 && exp_idx_q.size() > 0) begin
        e_idx = exp_idx_q.pop_front();
        n_cmp++;
        if (round_idx !== e_idx) begin
          n_err++;
          $display("FAIL two_round_idx c=%0d: got %0d want %0d", c, round_idx, e_idx);
        end
      end
      n_cmp++;
      if (out_we !== (c == 55) || busy !== (c != 56)) begin
        n_err++;
        $display("FAIL two_we_busy c=%0d: got we/busy=%b%b want %b%b", c, out_we, busy, c == 55, c != 56);
      end
      if (out_we === 1'b1 && exp_last_q.size() > 0) begin
        n_cmp++;
        if (out_last !== exp_last_q.pop_front()) begin
          n_err++;
          $display("FAIL two_out_last: got %b want 1", out_last);
        end
      end
    end
    n_cmp++;
    if (exp_idx_q.size() != 0 || exp_last_q.size() != 0) begin
      n_err++;
      $display("FAIL two_leftover: got idx_left=%0d last_left=%0d want 0 0", exp_idx_q.size(), exp_last_q.size());
    end
    exp_idx_q.delete(); exp_last_q.delete();
  endtask

  task automatic test_squeeze_stall();
    logic [31:0] pb0, ps0;
    logic [4:0]  e_idx;
    logic [0:0]  e_last;
    logic        exp_re, exp_we, stall;
    int          writes = 0;
    pb0 = perf_blocks; ps0 = perf_stalls;
    start_msg(1'b1, 16'd3, 3);
    exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b1);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      stall = (c >= 50 && c <= 53);
      in_valid = 1'b0; out_ready = !stall;
      #1;
      exp_re = (c >= 1 && c <= 24) || (c >= 26 && c <= 49) || (c >= 55 && c <= 78);
      exp_we = (c == 25) || (c == 54) || (c == 79);
      n_cmp++;
      if (round_en !== exp_re || out_we !== exp_we) begin
        n_err++;
        $display("FAIL sq_ctrl c=%0d: got re/we=%b%b want %b%b", c, round_en, out_we, exp_re, exp_we);
      end
      if (stall) begin
        n_cmp++;
        if ({out_we, state_reset, round_en, absorb_en, in_ack, ctrl_load, busy} !== 7'b0000001) begin
          n_err++;
          $display("FAIL sq_stall c=%0d: got %b want 0000001", c,
                   {out_we, state_reset, round_en, absorb_en, in_ack, ctrl_load, busy});
        end
      end
      if (round_en === 1'b1 && exp_idx_q.size() > 0) begin
        e_idx = exp_idx_q.pop_front();
        n_cmp++;
        if (round_idx !== e_idx) begin
          n_err++;
          $display("FAIL sq_round_idx c=%0d: got %0d want %0d", c, round_idx, e_idx);
        end
      end
      if (out_we === 1'b1 && exp_last_q.size() > 0) begin
        e_last = exp_last_q.pop_front();
        writes++;
        n_cmp++;
        if ({out_last, state_reset} !== {e_last, e_last}) begin
          n_err++;
          $display("FAIL sq_out_last c=%0d: got last/sr=%b want %b%b", c, {out_last, state_reset}, e_last, e_last);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || writes != 3 || exp_idx_q.size() != 0) begin
      n_err++;
      $display("FAIL sq_end: got busy=%b writes=%0d idx_left=%0d want 0 3 0", busy, writes, exp_idx_q.size());
    end
`ifdef PERMUTE_PERF_CNT_EN
    n_cmp++;
    if ((perf_stalls - ps0) !== 32'd4 || (perf_blocks - pb0) !== 32'd1) begin
      n_err++;
      $display("FAIL sq_perf: got stalls+%0d blocks+%0d want 4 1", perf_stalls - ps0, perf_blocks - pb0);
    end
`else
    n_cmp++;
    if (perf_stalls !== 32'd0 || perf_blocks !== 32'd0) begin
      n_err++;
      $display("FAIL sq_perf_off: got stalls=%0d blocks=%0d want 0 0 (pre %0d %0d)", perf_stalls, perf_blocks, ps0, pb0);
    end
`endif
    exp_idx_q.delete(); exp_last_q.delete();
  endtask

  // in_outblocks=0 behaves as 1; in_valid is held high throughout, so PERMUTE
  // and the DUMP write cycle must both leave it untaken.
  task automatic test_zero_out();
    int writes = 0;
    start_msg(1'b1, 16'd0, 1);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      in_valid = (c <= 25);
      #1;
      n_cmp++;
      if (in_ack !== 1'b0 || out_we !== (c == 25)) begin
        n_err++;
        $display("FAIL zero_ctrl c=%0d: got ack/we=%b%b want 0%b", c, in_ack, out_we, c == 25);
      end
      if (out_we === 1'b1) begin
        writes++;
        n_cmp++;
        if (out_last !== 1'b1) begin
          n_err++;
          $display("FAIL zero_out_last: got %b want 1", out_last);
        end
      end
    end
    n_cmp++;
    if (writes != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_end: got writes=%0d busy=%b want 1 0", writes, busy);
    end
    exp_idx_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [4:0] e_idx;
    int         bad_we = 0;
    start_msg(1'b1, 16'd1, 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (exp_idx_q.size() > 0) begin
        e_idx = exp_idx_q.pop_front();
        n_cmp++;
        if (round_en !== 1'b1 || round_idx !== e_idx) begin
          n_err++;
          $display("FAIL mid_round c=%0d: got re=%b idx=%0d want 1 %0d", c, round_en, round_idx, e_idx);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ack, out_we, out_last, state_reset, ctrl_load, absorb_en, round_en, round_idx, busy} !== '0) begin
        n_err++;
        $display("FAIL mid_rst_out k=%0d: got we=%b re=%b idx=%0d busy=%b want 0", k, out_we, round_en, round_idx, busy);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({state_reset, busy, out_we} !== 3'b100) begin
      n_err++;
      $display("FAIL mid_init: got sr/busy/we=%b want 100", {state_reset, busy, out_we});
    end
    n_cmp++;
    if (exp_idx_q.size() != 14) begin
      n_err++;
      $display("FAIL mid_rounds_left: got %0d want 14", exp_idx_q.size());
    end
    exp_idx_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (out_we !== 1'b0 || busy !== 1'b0) bad_we++;
    end
    n_cmp++;
    if (bad_we != 0) begin
      n_err++;
      $display("FAIL mid_no_write: got %0d bad cycles want 0", bad_we);
    end
    test_single("after_rst");
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single("single");
    test_unroll2();
    test_two_blocks();
    test_squeeze_stall();
    test_zero_out();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
